// File: rtl/fdc_disk_sched.sv
// fdc_disk_sched: two-requester arbiter that owns the floppy host channel.
// A granted request is issued to the host as a one-hot command word, then the
// scheduler waits for host_done (or a timeout), runs the done/ack handshake
// and reports a single-cycle done/err pulse to the owning requester.
module fdc_disk_sched #(
    parameter logic [23:0] TIMEOUT = 24'd8_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  cmd0,
    input  logic [1:0]  cmd1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic        busy,
    output logic [31:0] host_sr,
    input  logic        host_done,
    input  logic        host_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RELEASE,
        S_REPORT
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] sr_q, sr_d;
    logic [23:0] cnt_q, cnt_d;
    logic        last_q, last_d;    // requester served most recently
    logic        own_q, own_d;      // requester owning the current operation
    logic        eflag_q, eflag_d;  // error outcome of the current operation
    logic [1:0]  cmd_q, cmd_d;
    logic [15:0] addr_q, addr_d;
    logic        sel;

    assign grant   = grant_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = (state_q != S_IDLE);
    assign host_sr = sr_q;

    // Next-state and next-output logic for the scheduler FSM
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = 2'b00;
        err_d   = 2'b00;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        own_d   = own_q;
        eflag_d = eflag_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        sel     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    // On a tie the requester not served last wins
                    sel     = (req == 2'b11) ? ~last_q : req[1];
                    own_d   = sel;
                    grant_d = sel ? 2'b10 : 2'b01;
                    cmd_d   = sel ? cmd1 : cmd0;
                    addr_d  = sel ? addr1 : addr0;
                    if (cmd_d == 2'b11) begin
                        // Invalid command never reaches the host
                        eflag_d = 1'b1;
                        done_d  = grant_d;
                        err_d   = grant_d;
                        state_d = S_REPORT;
                    end else begin
                        eflag_d = 1'b0;
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                sr_d     = {16'h0000, addr_q};
                sr_d[17] = (cmd_q == 2'b01) && !own_q;
                sr_d[18] = (cmd_q == 2'b01) && own_q;
                sr_d[20] = (cmd_q == 2'b10) && !own_q;
                sr_d[21] = (cmd_q == 2'b10) && own_q;
                sr_d[24] = (cmd_q == 2'b00) && !own_q;
                sr_d[25] = (cmd_q == 2'b00) && own_q;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // host_done takes priority over a coincident timeout
                if (host_done) begin
                    sr_d[31:17] = '0;
                    sr_d[16]    = 1'b1;
                    eflag_d     = host_err;
                    state_d     = S_RELEASE;
                end else if (cnt_q == TIMEOUT - 24'd1) begin
                    sr_d[31:17] = '0;
                    eflag_d     = 1'b1;
                    state_d     = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_RELEASE: begin
                if (!host_done) begin
                    done_d  = grant_q;
                    err_d   = eflag_q ? grant_q : 2'b00;
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                grant_d = 2'b00;
                last_d  = own_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any operation silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            sr_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            own_q   <= 1'b0;
            eflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            own_q   <= own_d;
            eflag_q <= eflag_d;
        end
    end

    // Latched command and address of the granted requester
    always_ff @(posedge clk) begin
        cmd_q  <= cmd_d;
        addr_q <= addr_d;
    end

endmodule

// File: tb/tb_fdc_disk_sched.sv
// tb_fdc_disk_sched: directed scenarios plus randomized operations, checked
// against a transaction-level reference model of the scheduler.
module tb_fdc_disk_sched;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  cmd0 = 2'b00;
    logic [1:0]  cmd1 = 2'b00;
    logic [15:0] addr0 = 16'h0000;
    logic [15:0] addr1 = 16'h0000;
    logic [1:0]  grant, done, err;
    logic        busy;
    logic [31:0] host_sr;
    logic        host_done = 1'b0;
    logic        host_err = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: last served requester and host_sr after an op
    bit          m_last = 1'b1;
    logic [31:0] m_sr = 32'h0;

    fdc_disk_sched #(.TIMEOUT(24'(TO))) dut (
        .clk(clk), .rst(rst), .req(req), .cmd0(cmd0), .cmd1(cmd1),
        .addr0(addr0), .addr1(addr1), .grant(grant), .done(done), .err(err),
        .busy(busy), .host_sr(host_sr), .host_done(host_done), .host_err(host_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cmd_word(input logic [1:0] c, input bit drv,
                                             input logic [15:0] a);
        logic [31:0] w;
        w = {16'h0000, a};
        case (c)
            2'b00: w[drv ? 25 : 24] = 1'b1;
            2'b01: w[drv ? 18 : 17] = 1'b1;
            2'b10: w[drv ? 21 : 20] = 1'b1;
            default: ;
        endcase
        return w;
    endfunction

    // Transaction-level prediction of one operation
    task automatic model_op(input logic [1:0] r, input logic [1:0] c0, input logic [1:0] c1,
                            input logic [15:0] a0, input logic [15:0] a1,
                            input int dly, input logic he,
                            output logic [1:0] g, output logic [31:0] w_cmd,
                            output logic [31:0] w_end, output logic [1:0] e,
                            output int ncmd, output int lat);
        bit drv;
        bit ok;
        logic [1:0] c;
        logic [15:0] a;
        drv   = (r == 2'b11) ? !m_last : r[1];
        g     = drv ? 2'b10 : 2'b01;
        c     = drv ? c1 : c0;
        a     = drv ? a1 : a0;
        w_cmd = cmd_word(c, drv, a);
        if (c == 2'b11) begin
            ncmd  = 0;
            lat   = -1;
            e     = g;
            w_end = m_sr;
            w_cmd = 32'h0;
        end else begin
            ok    = (dly >= 0) && (dly < TO);
            ncmd  = ok ? dly + 1 : TO;
            lat   = 2;
            e     = ok ? (he ? g : 2'b00) : g;
            w_end = {15'h0000, ok, a};
        end
        m_sr   = w_end;
        m_last = drv;
    endtask

    // Drives one operation from IDLE to its done pulse and collects observations.
    // dly: WAIT cycles before host_done rises (-1 = never); hlen: host_done width.
    task automatic do_op(input logic [1:0] r, input logic [1:0] c0, input logic [1:0] c1,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input int dly, input int hlen, input logic he,
                         input bit drop_req, input bit keep_req,
                         output logic [1:0] g_first, output logic [31:0] sr_cmd,
                         output logic [31:0] sr_mid, output logic [31:0] sr_end,
                         output logic [1:0] d_obs, output logic [1:0] e_obs,
                         output logic [1:0] g_done, output int n_cmd, output int lat_cmd,
                         output int done_cyc, output logic [1:0] post_done,
                         output logic post_busy, output bit bad_shape, output bit tout);
        int cyc;
        int wcyc;
        bit seen;
        bit mid_seen;
        req = r; cmd0 = c0; cmd1 = c1; addr0 = a0; addr1 = a1; host_err = he;
        tick();
        g_first = grant;
        if (drop_req) req = 2'b00;
        cyc = 1; wcyc = 0; seen = 0; mid_seen = 0;
        sr_cmd = 32'h0; sr_mid = 32'h0; sr_end = 32'h0;
        d_obs = 2'b00; e_obs = 2'b00; g_done = 2'b00;
        n_cmd = 0; lat_cmd = -1; done_cyc = -1; bad_shape = 0; tout = 1;
        while (cyc < 200) begin
            if ($countones(grant) > 1 || $countones(done) > 1 ||
                $countones(host_sr[31:17]) > 1 || (done == 2'b00 && err != 2'b00))
                bad_shape = 1;
            if (host_sr[31:17] != 0) begin
                n_cmd++;
                if (!seen) begin
                    seen = 1; sr_cmd = host_sr; lat_cmd = cyc;
                end
            end else if (seen && !mid_seen) begin
                mid_seen = 1; sr_mid = host_sr;
            end
            if (done != 2'b00) begin
                d_obs = done; e_obs = err; sr_end = host_sr; g_done = grant;
                done_cyc = cyc; tout = 0;
                break;
            end
            if (seen) begin
                if (dly >= 0 && wcyc == dly) host_done = 1'b1;
                if (dly >= 0 && wcyc == dly + hlen) host_done = 1'b0;
                wcyc++;
            end
            tick();
            cyc++;
        end
        host_done = 1'b0;
        if (!keep_req) req = 2'b00;
        tick();
        post_done = done;
        post_busy = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b11;
        tick(); tick();
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b want 00", grant); end
        n_cmp++; if (done !== 2'b00) begin n_bad++; $display("FAIL reset_done: got %b want 00", done); end
        n_cmp++; if (err !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b want 00", err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (host_sr !== 32'h0) begin n_bad++; $display("FAIL reset_host_sr: got %h want 0", host_sr); end
        req = 2'b00; rst = 1'b0;
        m_last = 1'b1; m_sr = 32'h0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] g1, d, e, gd, pd, xg, xe;
        logic [31:0] sc, sm, se, xc, xs;
        logic pb;
        int nc, lc, dc, xn, xl;
        bit bs, to;
        logic [1:0] want_g [3];
        want_g[0] = 2'b01; want_g[1] = 2'b10; want_g[2] = 2'b01;
        for (int i = 0; i < 3; i++) begin
            model_op(2'b11, 2'b10, 2'b10, 16'h1234, 16'h4321, 3, 1'b0, xg, xc, xs, xe, xn, xl);
            do_op(2'b11, 2'b10, 2'b10, 16'h1234, 16'h4321, 3, 1, 1'b0, 0, i < 2,
                  g1, sc, sm, se, d, e, gd, nc, lc, dc, pd, pb, bs, to);
            n_cmp++; if (g1 !== want_g[i]) begin n_bad++; $display("FAIL b2b_grant%0d: got %b want %b", i, g1, want_g[i]); end
            n_cmp++; if (g1 !== xg) begin n_bad++; $display("FAIL b2b_model_grant%0d: got %b want %b", i, g1, xg); end
            n_cmp++; if (sc !== xc) begin n_bad++; $display("FAIL b2b_cmd%0d: got %h want %h", i, sc, xc); end
            n_cmp++; if (d !== xg || e !== 2'b00) begin n_bad++; $display("FAIL b2b_done%0d: got %b/%b want %b/00", i, d, e, xg); end
            n_cmp++; if (pd !== 2'b00 || bs || to) begin n_bad++; $display("FAIL b2b_pulse%0d: post_done %b shape %0d tout %0d want 00 0 0", i, pd, bs, to); end
        end
    endtask

    task automatic test_read_basic();
        logic [1:0] g1, d, e, gd, pd, xg, xe;
        logic [31:0] sc, sm, se, xc, xs;
        logic pb;
        int nc, lc, dc, xn, xl;
        bit bs, to;
        model_op(2'b01, 2'b01, 2'b00, 16'h8A05, 16'h0000, 5, 1'b0, xg, xc, xs, xe, xn, xl);
        do_op(2'b01, 2'b01, 2'b00, 16'h8A05, 16'h0000, 5, 2, 1'b0, 0, 0,
              g1, sc, sm, se, d, e, gd, nc, lc, dc, pd, pb, bs, to);
        n_cmp++; if (g1 !== 2'b01) begin n_bad++; $display("FAIL read_grant: got %b want 01", g1); end
        n_cmp++; if (lc !== 2) begin n_bad++; $display("FAIL read_latency: got %0d want 2", lc); end
        n_cmp++; if (sc !== 32'h00028A05) begin n_bad++; $display("FAIL read_cmd_word: got %h want 00028a05", sc); end
        n_cmp++; if (sm !== 32'h00018A05) begin n_bad++; $display("FAIL read_ack_word: got %h want 00018a05", sm); end
        n_cmp++; if (se !== 32'h00018A05) begin n_bad++; $display("FAIL read_hold_word: got %h want 00018a05", se); end
        n_cmp++; if (d !== 2'b01 || e !== 2'b00) begin n_bad++; $display("FAIL read_done: got %b/%b want 01/00", d, e); end
        n_cmp++; if (nc !== xn) begin n_bad++; $display("FAIL read_cmd_cycles: got %0d want %0d", nc, xn); end
        n_cmp++; if (pb !== 1'b0 || pd !== 2'b00) begin n_bad++; $display("FAIL read_idle_after: busy %b done %b want 0 00", pb, pd); end
    endtask

    task automatic test_timeout();
        logic [1:0] g1, d, e, gd, pd, xg, xe;
        logic [31:0] sc, sm, se, xc, xs;
        logic pb;
        int nc, lc, dc, xn, xl;
        bit bs, to;
        model_op(2'b10, 2'b01, 2'b00, 16'h0000, 16'h3C7E, -1, 1'b0, xg, xc, xs, xe, xn, xl);
        do_op(2'b10, 2'b01, 2'b00, 16'h0000, 16'h3C7E, -1, 0, 1'b0, 0, 0,
              g1, sc, sm, se, d, e, gd, nc, lc, dc, pd, pb, bs, to);
        n_cmp++; if (sc[25] !== 1'b1 || sc !== xc) begin n_bad++; $display("FAIL tout_cmd: got %h want %h", sc, xc); end
        n_cmp++; if (nc !== TO) begin n_bad++; $display("FAIL tout_cmd_cycles: got %0d want %0d", nc, TO); end
        n_cmp++; if (d !== 2'b10 || e !== 2'b10) begin n_bad++; $display("FAIL tout_done: got %b/%b want 10/10", d, e); end
        n_cmp++; if (se[16] !== 1'b0 || se !== xs) begin n_bad++; $display("FAIL tout_word: got %h want %h", se, xs); end
    endtask

    task automatic test_invalid();
        logic [1:0] g1, d, e, gd, pd, xg, xe;
        logic [31:0] sc, sm, se, xc, xs;
        logic pb;
        int nc, lc, dc, xn, xl;
        bit bs, to;
        model_op(2'b01, 2'b11, 2'b00, 16'hFFFF, 16'h0000, 2, 1'b0, xg, xc, xs, xe, xn, xl);
        do_op(2'b01, 2'b11, 2'b00, 16'hFFFF, 16'h0000, 2, 1, 1'b0, 0, 0,
              g1, sc, sm, se, d, e, gd, nc, lc, dc, pd, pb, bs, to);
        n_cmp++; if (nc !== 0) begin n_bad++; $display("FAIL inv_no_cmd: got %0d cycles want 0", nc); end
        n_cmp++; if (d !== 2'b01 || e !== 2'b01) begin n_bad++; $display("FAIL inv_done: got %b/%b want 01/01", d, e); end
        n_cmp++; if (to || dc > 3) begin n_bad++; $display("FAIL inv_latency: got %0d want <=3", dc); end
        n_cmp++; if (se !== xs) begin n_bad++; $display("FAIL inv_sr_hold: got %h want %h", se, xs); end
    endtask

    task automatic test_coincide();
        logic [1:0] g1, d, e, gd, pd, xg, xe;
        logic [31:0] sc, sm, se, xc, xs;
        logic pb;
        int nc, lc, dc, xn, xl;
        bit bs, to;
        model_op(2'b01, 2'b10, 2'b00, 16'h5A5A, 16'h0000, TO - 1, 1'b0, xg, xc, xs, xe, xn, xl);
        do_op(2'b01, 2'b10, 2'b00, 16'h5A5A, 16'h0000, TO - 1, 1, 1'b0, 0, 0,
              g1, sc, sm, se, d, e, gd, nc, lc, dc, pd, pb, bs, to);
        n_cmp++; if (d !== 2'b01 || e !== 2'b00) begin n_bad++; $display("FAIL coin_done: got %b/%b want 01/00", d, e); end
        n_cmp++; if (se !== 32'h00015A5A) begin n_bad++; $display("FAIL coin_word: got %h want 00015a5a", se); end
        n_cmp++; if (nc !== xn) begin n_bad++; $display("FAIL coin_cycles: got %0d want %0d", nc, xn); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] g1, d, e, gd, pd, xg, xe;
        logic [31:0] sc, sm, se, xc, xs;
        logic pb;
        int nc, lc, dc, xn, xl;
        bit bs, to;
        bit stray;
        req = 2'b01; cmd0 = 2'b01; addr0 = 16'h0F0F;
        tick(); tick(); tick();
        n_cmp++; if (host_sr[17] !== 1'b1) begin n_bad++; $display("FAIL rmid_cmd: got %b want 1", host_sr[17]); end
        rst = 1'b1; req = 2'b00;
        tick();
        rst = 1'b0;
        m_last = 1'b1; m_sr = 32'h0;
        n_cmp++; if (host_sr !== 32'h0 || busy !== 1'b0 || grant !== 2'b00) begin n_bad++; $display("FAIL rmid_clear: sr %h busy %b grant %b want 0 0 00", host_sr, busy, grant); end
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            if (done !== 2'b00) stray = 1;
            tick();
        end
        n_cmp++; if (stray) begin n_bad++; $display("FAIL rmid_no_done: got a done pulse want none"); end
        model_op(2'b11, 2'b10, 2'b01, 16'h2222, 16'h3333, 2, 1'b1, xg, xc, xs, xe, xn, xl);
        do_op(2'b11, 2'b10, 2'b01, 16'h2222, 16'h3333, 2, 1, 1'b1, 0, 0,
              g1, sc, sm, se, d, e, gd, nc, lc, dc, pd, pb, bs, to);
        n_cmp++; if (g1 !== xg || sc !== xc) begin n_bad++; $display("FAIL rmid_fresh: grant %b cmd %h want %b %h", g1, sc, xg, xc); end
        n_cmp++; if (d !== xg || e !== xe || se !== xs) begin n_bad++; $display("FAIL rmid_fresh_done: %b/%b %h want %b/%b %h", d, e, se, xg, xe, xs); end
    endtask

    task automatic test_random();
        logic [1:0] g1, d, e, gd, pd, xg, xe, r, c0, c1;
        logic [31:0] sc, sm, se, xc, xs;
        logic [15:0] a0, a1;
        logic pb, he;
        int nc, lc, dc, xn, xl, dly, hlen;
        bit bs, to, drop;
        for (int i = 0; i < 40; i++) begin
            r    = 2'($urandom_range(1, 3));
            c0   = 2'($urandom_range(0, 3));
            c1   = 2'($urandom_range(0, 3));
            a0   = 16'($urandom);
            a1   = 16'($urandom);
            dly  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO + 4));
            hlen = int'($urandom_range(1, 3));
            he   = 1'($urandom);
            drop = 1'($urandom);
            model_op(r, c0, c1, a0, a1, dly, he, xg, xc, xs, xe, xn, xl);
            do_op(r, c0, c1, a0, a1, dly, hlen, he, drop, 0,
                  g1, sc, sm, se, d, e, gd, nc, lc, dc, pd, pb, bs, to);
            n_cmp++;
            if (to || g1 !== xg || gd !== xg || sc !== xc || se !== xs || d !== xg ||
                e !== xe || nc !== xn || lc !== xl || bs || pd !== 2'b00 || pb !== 1'b0) begin
                n_bad++;
                $display("FAIL rand%0d: g %b/%b cmd %h end %h done %b err %b ncmd %0d lat %0d shape %0d tout %0d want g %b cmd %h end %h done %b err %b ncmd %0d lat %0d",
                         i, g1, gd, sc, se, d, e, nc, lc, bs, to, xg, xc, xs, xg, xe, xn, xl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_read_basic();
        test_timeout();
        test_invalid();
        test_coincide();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fdc_disk_sched.md
FDC_DISK_SCHED -- requirements
Module: fdc_disk_sched

Interface
REQ-001 Parameter TIMEOUT, default 24'd8_000_000, cycles in WAIT before a request is aborted; legal range 2 to 2^24-1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  2  per-requester request; requester i targets drive i (0=A, 1=B).
REQ-005 cmd0, cmd1  input  2 each  command: 00 seek, 01 read sector, 10 write sector, 11 invalid.
REQ-006 addr0, addr1  input  16 each  {head, cyl[6:0], sector[7:0]}.
REQ-007 grant  output  2  one-hot owner of host channel; 00 when idle.
REQ-008 done  output  2  one-cycle completion pulse per requester.
REQ-009 err  output  2  per-requester error; valid only in the cycle its done bit is high, else 0.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 host_sr  output  32  host command word: [15:0] addr, [16] ack-of-ack, [17] read A, [18] read B, [20] write A, [21] write B, [24] seek A, [25] seek B; all other bits 0.
REQ-012 host_done  input  1  host finished current command (level).
REQ-013 host_err  input  1  host error; sampled only with host_done=1.

Function
REQ-014 States: IDLE, ISSUE, WAIT, RELEASE, REPORT.
REQ-015 IDLE: if exactly one req bit is set, grant that requester; if both are set, grant the requester not served last (round-robin pointer); latch that requester's cmd and addr; go ISSUE if cmd != 11, else go REPORT with err flag set.
REQ-016 grant asserts the cycle after IDLE samples req and holds until the REPORT cycle inclusive.
REQ-017 ISSUE (1 cycle): next cycle host_sr[15:0]=latched addr, exactly one command bit set per cmd and drive, [16]=0; go WAIT.
REQ-018 Latency: req sampled at edge N, grant visible after N+1, host_sr command bit visible after N+2.
REQ-019 WAIT: on host_done=1, clear command bits, set [16]=1, capture host_err, go RELEASE.
REQ-020 WAIT: an internal counter, cleared on ISSUE entry, increments each WAIT cycle; when it reaches TIMEOUT-1 with host_done=0, clear command bits, leave [16]=0, set err flag, go RELEASE.
REQ-021 If host_done and timeout coincide, host_done wins and err equals host_err.
REQ-022 RELEASE: remain until host_done=0, then go REPORT; [16] remains 1 throughout.
REQ-023 REPORT (1 cycle): done[g]=1, err[g]=latched error flag; round-robin pointer updated to g; go IDLE.
REQ-024 host_sr[15:0] and [16] hold their values after completion until the next ISSUE.
REQ-025 req changes after grant (including deassert) are ignored until REPORT; the operation still completes and reports.
REQ-026 A requester holding req through done is re-arbitrated in the IDLE cycle following REPORT (fairness via the pointer).
REQ-027 At most one host_sr command bit is ever set; done and grant are never multi-bit.

Reset
REQ-028 rst=1 at any edge, including mid-operation: state IDLE, grant=00, done=00, err=00, busy=0, host_sr=0, timeout counter 0, pointer set so requester 0 wins the first tie; no done pulse for an aborted operation.

Verification
REQ-029 req=01, cmd0=01, addr0=16'h8A05; host_done high 5 cycles after ISSUE, host_err=0 -> host_sr=32'h00028A05 then 32'h00018A05; done=01, err=00 after host_done drops.
REQ-030 req=11 held, both cmd=10 -> grants alternate 01,10,01; host_sr[20] then [21]; each done pulse single-cycle.
REQ-031 TIMEOUT=16, cmd1=00, host_done never asserts -> host_sr[25] high for 16 cycles then cleared; done=10, err=10; [16]=0.
REQ-032 cmd0=11 -> no host_sr command bit ever set; done=01, err=01 within 3 cycles of req.
REQ-033 rst asserted during WAIT with host_sr[17]=1 -> next cycle host_sr=0, busy=0, no done pulse; a fresh req then proceeds normally.
REQ-034 host_done and timeout in the same cycle with host_err=0 -> err=00 at done.
